mu0_sequencer: RTL and testbench
================================

Name: mu0_sequencer

Overview:
- Upstream control stage for the MU0/ARMish decoder: owns the instruction register and the FETCH/EXEC1/EXEC2 phase sequence the decoder consumes.
- Latches the fetched word from program memory, takes the decoder's EXTRA to select a second execute cycle, stops on STP, and supports run, halt and single-step.
- Provides instruction and cycle counters for debug display.

Parameters:
- CNT_W, 32, width of INSTR_CNT and CYCLE_CNT.
- IR_RESET, 16'h0000, IR value after reset.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  level; a rising edge leaves HALT.
- STEP_MODE  in  1  1 = pause after every instruction.
- STEP  in  1  level; a rising edge releases one instruction in step mode.
- MEM_Q  in  16  program memory read data, valid during FETCH (memory timing handled outside).
- EXTRA  in  1  from the decoder; 1 during EXEC1 = instruction needs EXEC2.
- FETCH  out  1  fetch phase, registered.
- EXEC1  out  1  first execute phase, registered.
- EXEC2  out  1  second execute phase, registered.
- IR  out  16  instruction register.
- HALTED  out  1  1 in HALT state.
- PAUSED  out  1  1 in PAUSE state.
- INSTR_CNT  out  CNT_W  retired instructions.
- CYCLE_CNT  out  CNT_W  clocks spent in FETCH/EXEC1/EXEC2.

Behaviour:
- Reset is asynchronous and active-low; all registers clear immediately on RESET_N low.
- Reset values: state=HALT, FETCH=EXEC1=EXEC2=0, IR=IR_RESET, HALTED=1, PAUSED=0, counters=0, both edge-detect flops=0.
- States: HALT, FETCH, EXEC1, EXEC2, PAUSE (one-hot encoding).
- FETCH/EXEC1/EXEC2/HALTED/PAUSED are direct state-register bits. Exactly one of the five is high at all times.
- Edge detection: start_edge = START & !start_q and step_edge = STEP & !STEP_q, with the _q flops sampled every clock. Inputs are assumed synchronous to CLOCK.
- HALT: on start_edge go to FETCH; otherwise stay.
- FETCH: IR <= MEM_Q; go to EXEC1. One clock only, no stall.
- EXEC1:
  - If IR[15:12]==4'b0111 (STP), go to HALT; not retired.
  - Else if EXTRA, go to EXEC2.
  - Else the instruction retires: go to PAUSE if STEP_MODE, otherwise FETCH.
- EXEC2: the instruction retires; go to PAUSE if STEP_MODE, otherwise FETCH.
- PAUSE:
  - On step_edge, go to FETCH.
  - If STEP_MODE drops, go to FETCH on the next edge.
  - START is ignored.
- IR is written only on the FETCH->EXEC1 edge. It holds through HALT and PAUSE.
- INSTR_CNT increments by 1 on each retirement edge and wraps modulo 2^CNT_W.
- CYCLE_CNT increments on every clock where FETCH|EXEC1|EXEC2 is high and wraps modulo 2^CNT_W. It is unchanged in HALT and PAUSE.
- EXTRA is sampled only in EXEC1; it is ignored in every other state.
- start_edge and step_edge together in HALT: go to FETCH (start wins; step has no effect).
- STEP_MODE set mid-instruction: takes effect at that instruction's retirement.
- Reset mid-EXEC2: return to HALT immediately; the partial instruction is not counted.
- Timing:
  - Non-EXTRA instructions take 2 clocks per instruction when free-running.
  - EXTRA instructions take 3.
  - From start_edge, FETCH is high on the next clock.

Decomposition:
- Shared package mu0_pkg: state enum {HALT, FETCH, EXEC1, EXEC2, PAUSE}, opcode constants (OP_STP=4'b0111, plus the other MU0 opcodes for reuse by the decoder), IR width constant 16.
- Optional sub-module mu0_edge_det, a one-flop rising-edge detector instantiated for START and STEP. Counters stay inline.

Test Plan:
- Reset then free-run:
  - Stimulus: reset, START pulse; MEM_Q=16'h2005 (ADD) with EXTRA=1 in EXEC1, then 16'h1003 (STA) with EXTRA=0.
  - Required: phase sequence F,E1,E2,F,E1,F; IR=2005 then 1003; INSTR_CNT=2, CYCLE_CNT=5 after the second retirement.
- STP handling:
  - Stimulus: MEM_Q=16'h7000.
  - Required: F,E1 then HALTED=1 on the next clock; INSTR_CNT unchanged; IR=16'h7000 held; restarts only on a new START edge.
- Single-step:
  - Stimulus: STEP_MODE=1, START, then two STEP edges 5 clocks apart, each instruction an LDI (EXTRA=0).
  - Required: PAUSED=1 after each E1; FETCH follows each STEP edge by one clock; CYCLE_CNT=6 and INSTR_CNT=3; PAUSED still 1 at end.
- STEP held high:
  - Stimulus: STEP held high for 10 clocks while in PAUSE.
  - Required: exactly one instruction executes.
- Async reset mid-operation:
  - Stimulus: drop RESET_N in EXEC2 between clock edges.
  - Required: all phase outputs 0, HALTED=1, IR=0 and counters=0 before the next edge.
- Counter wrap:
  - Stimulus: CNT_W=4, free-run 16 non-EXTRA instructions.
  - Required: INSTR_CNT wraps to 0, CYCLE_CNT=0 (32 mod 16).

Source files
------------

// File: rtl/mu0_pkg.sv
// mu0_pkg: shared MU0 state encoding, opcodes and widths for the sequencer and decoder.
package mu0_pkg;
    localparam int IR_W = 16;
    typedef enum logic [2:0] {HALT, FETCH, EXEC1, EXEC2, PAUSE} state_e;
    localparam logic [4:0] ST_HALT  = 5'b00001;
    localparam logic [4:0] ST_FETCH = 5'b00010;
    localparam logic [4:0] ST_EXEC1 = 5'b00100;
    localparam logic [4:0] ST_EXEC2 = 5'b01000;
    localparam logic [4:0] ST_PAUSE = 5'b10000;
    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_STA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_JMP = 4'b0100;
    localparam logic [3:0] OP_JGE = 4'b0101;
    localparam logic [3:0] OP_JNE = 4'b0110;
    localparam logic [3:0] OP_STP = 4'b0111;
endpackage

// File: rtl/mu0_edge_det.sv
// mu0_edge_det: one-flop rising-edge detector for synchronous level inputs.
module mu0_edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_edge
);
    logic r_q;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_q <= 1'b0;
        else          r_q <= i_d;
    assign o_edge = i_d & ~r_q;
endmodule

// File: rtl/mu0_sequencer.sv
// mu0_sequencer: MU0 instruction register and one-hot FETCH/EXEC1/EXEC2 phase sequencer
// with run/halt/single-step control and debug instruction/cycle counters.
module mu0_sequencer
    import mu0_pkg::*;
#(
    parameter int              CNT_W    = 32,
    parameter logic [IR_W-1:0] IR_RESET = 16'h0000
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic             i_step_mode,
    input  logic             i_step,
    input  logic [IR_W-1:0]  i_mem_q,
    input  logic             i_extra,
    output logic             o_fetch,
    output logic             o_exec1,
    output logic             o_exec2,
    output logic [IR_W-1:0]  o_ir,
    output logic             o_halted,
    output logic             o_paused,
    output logic [CNT_W-1:0] o_instr_cnt,
    output logic [CNT_W-1:0] o_cycle_cnt
);
    logic [4:0]       r_state;
    logic [4:0]       w_next;
    logic [4:0]       w_done;
    logic [IR_W-1:0]  r_ir;
    logic [CNT_W-1:0] r_instr_cnt;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic             w_start_edge;
    logic             w_step_edge;
    logic             w_stp;
    logic             w_retire;
    logic             w_active;

    mu0_edge_det u_start_det (.i_clk(i_clock), .i_rst_n(i_reset_n), .i_d(i_start), .o_edge(w_start_edge));
    mu0_edge_det u_step_det  (.i_clk(i_clock), .i_rst_n(i_reset_n), .i_d(i_step),  .o_edge(w_step_edge));

    assign w_stp    = r_ir[15:12] == OP_STP;
    assign w_retire = (r_state[EXEC1] & ~w_stp & ~i_extra) | r_state[EXEC2];
    assign w_active = r_state[FETCH] | r_state[EXEC1] | r_state[EXEC2];
    assign w_done   = i_step_mode ? ST_PAUSE : ST_FETCH;

    // Start beats step in HALT because HALT only looks at start_edge.
    always_comb
        w_next = r_state[HALT]  ? (w_start_edge ? ST_FETCH : ST_HALT) :
                 r_state[FETCH] ? ST_EXEC1 :
                 r_state[EXEC1] ? (w_stp ? ST_HALT : i_extra ? ST_EXEC2 : w_done) :
                 r_state[EXEC2] ? w_done :
                 (w_step_edge | ~i_step_mode) ? ST_FETCH : ST_PAUSE;

    always_ff @(posedge i_clock or negedge i_reset_n)
        if (!i_reset_n) begin
            r_state     <= ST_HALT;
            r_ir        <= IR_RESET;
            r_instr_cnt <= '0;
            r_cycle_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state[FETCH]) r_ir <= i_mem_q;
            if (w_retire) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            if (w_active) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        end

    assign o_fetch     = r_state[FETCH];
    assign o_exec1     = r_state[EXEC1];
    assign o_exec2     = r_state[EXEC2];
    assign o_halted    = r_state[HALT];
    assign o_paused    = r_state[PAUSE];
    assign o_ir        = r_ir;
    assign o_instr_cnt = r_instr_cnt;
    assign o_cycle_cnt = r_cycle_cnt;
endmodule

// File: tb/tb_mu0_sequencer.sv
// tb_mu0_sequencer: directed scoreboard bench; a 32-bit and a 4-bit counter instance share stimulus.
module tb_mu0_sequencer;
    localparam logic [4:0] F  = 5'b10000;
    localparam logic [4:0] E1 = 5'b01000;
    localparam logic [4:0] E2 = 5'b00100;
    localparam logic [4:0] H  = 5'b00010;
    localparam logic [4:0] P  = 5'b00001;

    typedef struct {
        logic [4:0]  ph;
        logic [15:0] ir;
        logic [31:0] ic;
        logic [31:0] cc;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, step_mode, step, extra;
    logic [15:0] mem_q;
    logic        fetch, exec1, exec2, halted, paused;
    logic [15:0] ir;
    logic [31:0] icnt, ccnt;
    logic        n_fetch, n_exec1, n_exec2, n_halted, n_paused;
    logic [15:0] n_ir;
    logic [3:0]  n_icnt, n_ccnt;
    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mu0_sequencer dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_start(start), .i_step_mode(step_mode),
        .i_step(step), .i_mem_q(mem_q), .i_extra(extra),
        .o_fetch(fetch), .o_exec1(exec1), .o_exec2(exec2), .o_ir(ir),
        .o_halted(halted), .o_paused(paused), .o_instr_cnt(icnt), .o_cycle_cnt(ccnt)
    );

    mu0_sequencer #(.CNT_W(4)) dut_n (
        .i_clock(clk), .i_reset_n(rst_n), .i_start(start), .i_step_mode(step_mode),
        .i_step(step), .i_mem_q(mem_q), .i_extra(extra),
        .o_fetch(n_fetch), .o_exec1(n_exec1), .o_exec2(n_exec2), .o_ir(n_ir),
        .o_halted(n_halted), .o_paused(n_paused), .o_instr_cnt(n_icnt), .o_cycle_cnt(n_ccnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: every falling edge, compare the DUT against the oldest pending expectation.
    always @(negedge clk)
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.nm, "_phase"}, {27'd0, fetch, exec1, exec2, halted, paused}, {27'd0, e.ph});
            chk({e.nm, "_ir"}, {16'd0, ir}, {16'd0, e.ir});
            chk({e.nm, "_icnt"}, icnt, e.ic);
            chk({e.nm, "_ccnt"}, ccnt, e.cc);
            chk({e.nm, "_n_icnt"}, {28'd0, n_icnt}, {28'd0, e.ic[3:0]});
            chk({e.nm, "_n_ccnt"}, {28'd0, n_ccnt}, {28'd0, e.cc[3:0]});
        end

    task automatic expect_now(input logic [4:0] ph, input logic [15:0] eir,
                              input int ic, input int cc, input string nm);
        exp_t e;
        e.ph = ph; e.ir = eir; e.ic = ic; e.cc = cc; e.nm = nm;
        sb.push_back(e);
    endtask

    // Drive this cycle's inputs, queue the state expected during this cycle, advance one clock.
    task automatic cyc(input logic st, input logic sm, input logic sp, input logic [15:0] mq,
                       input logic ex, input logic [4:0] ph, input logic [15:0] eir,
                       input int ic, input int cc, input string nm);
        start = st; step_mode = sm; step = sp; mem_q = mq; extra = ex;
        expect_now(ph, eir, ic, cc, nm);
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; start = 0; step_mode = 0; step = 0; mem_q = 0; extra = 0;
        @(posedge clk);
        #2;
        cyc(0, 0, 0, 16'h0000, 0, H, 16'h0000, 0, 0, "reset");
        rst_n = 1'b1;
        cyc(0, 0, 0, 16'h0000, 0, H, 16'h0000, 0, 0, "idle");
        cyc(1, 0, 0, 16'h0000, 0, H, 16'h0000, 0, 0, "start");
        cyc(1, 0, 0, 16'h2005, 0, F, 16'h0000, 0, 0, "f_add");
        cyc(1, 0, 0, 16'h0000, 1, E1, 16'h2005, 0, 1, "e1_add");
        cyc(1, 0, 0, 16'h0000, 0, E2, 16'h2005, 0, 2, "e2_add");
        cyc(1, 0, 0, 16'h1003, 0, F, 16'h2005, 1, 3, "f_sta");
        cyc(1, 0, 0, 16'h0000, 0, E1, 16'h1003, 1, 4, "e1_sta");
        cyc(1, 0, 0, 16'h7000, 0, F, 16'h1003, 2, 5, "f_stp");
        cyc(1, 0, 0, 16'h0000, 1, E1, 16'h7000, 2, 6, "e1_stp");
        cyc(1, 0, 0, 16'h0000, 0, H, 16'h7000, 2, 7, "stp_halt");
        cyc(0, 0, 0, 16'h0000, 0, H, 16'h7000, 2, 7, "halt_hold");
        cyc(0, 1, 1, 16'h0000, 0, H, 16'h7000, 2, 7, "halt_step_ign");
        cyc(1, 1, 1, 16'h0000, 0, H, 16'h7000, 2, 7, "restart");
        cyc(1, 1, 1, 16'h0001, 0, F, 16'h7000, 2, 7, "ss_f1");
        cyc(1, 1, 1, 16'h0000, 0, E1, 16'h0001, 2, 8, "ss_e1");
        cyc(1, 1, 1, 16'h0000, 0, P, 16'h0001, 3, 9, "ss_pause1");
        cyc(1, 1, 0, 16'h0000, 0, P, 16'h0001, 3, 9, "ss_pause2");
        cyc(1, 1, 1, 16'h0000, 0, P, 16'h0001, 3, 9, "ss_step1");
        cyc(1, 1, 1, 16'h0002, 0, F, 16'h0001, 3, 9, "ss_f2");
        cyc(1, 1, 1, 16'h0000, 0, E1, 16'h0002, 3, 10, "ss_e2");
        for (int i = 0; i < 10; i++)
            cyc(1, 1, 1, 16'h0000, 0, P, 16'h0002, 4, 11, "step_held");
        cyc(1, 1, 0, 16'h0000, 0, P, 16'h0002, 4, 11, "ss_low");
        cyc(1, 1, 1, 16'h0000, 0, P, 16'h0002, 4, 11, "ss_step2");
        cyc(1, 1, 1, 16'h0003, 0, F, 16'h0002, 4, 11, "ss_f3");
        cyc(1, 1, 1, 16'h0000, 0, E1, 16'h0003, 4, 12, "ss_e3");
        cyc(1, 0, 0, 16'h0000, 0, P, 16'h0003, 5, 13, "mode_drop");
        cyc(1, 0, 0, 16'h2006, 0, F, 16'h0003, 5, 13, "f_add2");
        cyc(1, 0, 0, 16'h0000, 1, E1, 16'h2006, 5, 14, "e1_add2");
        start = 0; step_mode = 0; step = 0; extra = 0;
        rst_n = 1'b0;
        expect_now(H, 16'h0000, 0, 0, "async_rst_e2");
        @(posedge clk);
        #2;
        cyc(0, 0, 0, 16'h0000, 0, H, 16'h0000, 0, 0, "rst_hold");
        rst_n = 1'b1;
        cyc(0, 0, 0, 16'h0000, 0, H, 16'h0000, 0, 0, "wrap_idle");
        cyc(1, 0, 0, 16'h0000, 0, H, 16'h0000, 0, 0, "wrap_start");
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 0, 16'h1000 | 16'(i), 0, F, (i == 0) ? 16'h0000 : (16'h1000 | 16'(i - 1)),
                i, 2 * i, "wrap_f");
            cyc(1, 0, 0, 16'h0000, 0, E1, 16'h1000 | 16'(i), i, 2 * i + 1, "wrap_e1");
        end
        cyc(1, 0, 0, 16'h0000, 0, F, 16'h100F, 16, 32, "wrap_end");
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
